// File: rtl/input_conditioner.sv
// input_conditioner
//   Per-channel conditioning of asynchronous raw inputs: a synchronizer chain,
//   a debouncer that accepts a new level only after it has persisted for
//   DEBOUNCE_CYCLES consecutive cycles, registered edge pulses and a sticky
//   request flag.
//
// Ports
//   clock    rising-edge clock for every flop
//   Reset_n  synchronous active-low reset; clears all state, overrides din/clr
//   din      [N_CH] asynchronous raw inputs
//   clr      [N_CH] synchronous clear of pending, per channel
//   level    [N_CH] debounced, synchronized level
//   rise     [N_CH] one-cycle pulse on an accepted 0->1 of level
//   fall     [N_CH] one-cycle pulse on an accepted 1->0 of level
//   pending  [N_CH] sticky flag set by rise, cleared by clr (set wins)

// One channel; every output is a flop, so nothing from din/clr reaches an
// output combinationally.
module input_conditioner_lane #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic Reset_n,
    input  logic din,
    input  logic clr,
    output logic level,
    output logic rise,
    output logic fall,
    output logic pending
);
    localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [CW-1:0]          cnt_q;
    logic                   s;
    logic                   mismatch;
    logic                   accept;

    assign s        = sync_q[SYNC_STAGES-1];
    assign mismatch = (s != level);
    // Mismatch has now persisted DEBOUNCE_CYCLES edges in a row (this one included).
    assign accept   = mismatch && (cnt_q == CNT_LAST);

    always_ff @(posedge clock) begin
        if (!Reset_n) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
            pending <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], din};

            // Any return to match restarts the count; acceptance also restarts it.
            if (!mismatch || accept)
                cnt_q <= '0;
            else
                cnt_q <= cnt_q + CNT_ONE;

            if (accept)
                level <= s;

            rise    <= accept &  s;
            fall    <= accept & ~s;
            // Set takes priority over clear so a request arriving with clr is kept.
            pending <= (accept & s) | (pending & ~clr);
        end
    end
endmodule

module input_conditioner #(
    parameter int N_CH            = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic            clock,
    input  logic            Reset_n,
    input  logic [N_CH-1:0] din,
    input  logic [N_CH-1:0] clr,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] rise,
    output logic [N_CH-1:0] fall,
    output logic [N_CH-1:0] pending
);
    for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
        input_conditioner_lane #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_lane (
            .clock   (clock),
            .Reset_n (Reset_n),
            .din     (din[ch]),
            .clr     (clr[ch]),
            .level   (level[ch]),
            .rise    (rise[ch]),
            .fall    (fall[ch]),
            .pending (pending[ch])
        );
    end
endmodule

// File: tb/tb_input_conditioner.sv
// Testbench for input_conditioner: a default instance (4 ch, 2 sync, 4 debounce)
// and a fast instance (8 ch, 3 sync, 1 debounce), each compared every cycle
// against a window-based reference model, plus hand-computed literal checks.
module tb_input_conditioner;
    typedef logic [7:0] vec_t;

    logic       clock = 1'b0;
    logic       Reset_n;
    logic [3:0] din_a, clr_a, lvl_a, rise_a, fall_a, pend_a;
    logic [7:0] din_b, clr_b, lvl_b, rise_b, fall_b, pend_b;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    input_conditioner #(.N_CH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut_a (
        .clock(clock), .Reset_n(Reset_n), .din(din_a), .clr(clr_a),
        .level(lvl_a), .rise(rise_a), .fall(fall_a), .pending(pend_a));

    input_conditioner #(.N_CH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1)) dut_b (
        .clock(clock), .Reset_n(Reset_n), .din(din_b), .clr(clr_b),
        .level(lvl_b), .rise(rise_b), .fall(fall_b), .pending(pend_b));

    task automatic check(input string nm, input vec_t act, input vec_t exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model. hist[m][k] is din as sampled k edges ago; the
    // synchronized value used at this edge is hist[m][S]. A level flips once
    // the last D synchronized samples all disagree with it. Reset wipes the
    // history to zeros, which is what discards any partial run.
    vec_t m_hist [2][16];
    vec_t m_lvl  [2];
    vec_t m_rise [2];
    vec_t m_fall [2];
    vec_t m_pend [2];

    function automatic int s_of(input int m);   return (m == 0) ? 2 : 3; endfunction
    function automatic int d_of(input int m);   return (m == 0) ? 4 : 1; endfunction
    function automatic int nch_of(input int m); return (m == 0) ? 4 : 8; endfunction

    initial begin
        vec_t dv, cv;
        bit   run;
        for (int m = 0; m < 2; m++) begin
            for (int k = 0; k < 16; k++) m_hist[m][k] = '0;
            m_lvl[m] = '0; m_rise[m] = '0; m_fall[m] = '0; m_pend[m] = '0;
        end
        forever begin
            @(posedge clock);
            for (int m = 0; m < 2; m++) begin
                dv = (m == 0) ? {4'b0, din_a} : din_b;
                cv = (m == 0) ? {4'b0, clr_a} : clr_b;
                if (!Reset_n) begin
                    for (int k = 0; k < 16; k++) m_hist[m][k] = '0;
                    m_lvl[m] = '0; m_rise[m] = '0; m_fall[m] = '0; m_pend[m] = '0;
                end else begin
                    for (int k = 15; k > 0; k--) m_hist[m][k] = m_hist[m][k-1];
                    m_hist[m][0] = dv;
                    m_rise[m] = '0;
                    m_fall[m] = '0;
                    for (int ch = 0; ch < nch_of(m); ch++) begin
                        run = 1'b1;
                        for (int t = 0; t < d_of(m); t++)
                            if (m_hist[m][s_of(m) + t][ch] == m_lvl[m][ch]) run = 1'b0;
                        if (run) begin
                            m_lvl[m][ch] = ~m_lvl[m][ch];
                            if (m_lvl[m][ch]) m_rise[m][ch] = 1'b1;
                            else              m_fall[m][ch] = 1'b1;
                        end
                    end
                    m_pend[m] = m_rise[m] | (m_pend[m] & ~cv);
                end
            end
        end
    end

    // Per-cycle comparison, away from the active edge.
    initial begin
        @(posedge clock);
        forever begin
            @(negedge clock);
            check("a.level",   {4'b0, lvl_a},  m_lvl[0]);
            check("a.rise",    {4'b0, rise_a}, m_rise[0]);
            check("a.fall",    {4'b0, fall_a}, m_fall[0]);
            check("a.pending", {4'b0, pend_a}, m_pend[0]);
            check("b.level",   lvl_b,  m_lvl[1]);
            check("b.rise",    rise_b, m_rise[1]);
            check("b.fall",    fall_b, m_fall[1]);
            check("b.pending", pend_b, m_pend[1]);
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clock);
    endtask

    logic [3:0] pat  [5] = '{4'b1010, 4'b0101, 4'b1111, 4'b0000, 4'b0110};
    int         hold [5] = '{2, 5, 7, 3, 9};

    initial begin
        Reset_n = 1'b0;
        din_a = '0; clr_a = '0; din_b = '0; clr_b = '0;
        cyc(3);
        check("reset.level_a",   {4'b0, lvl_a},  8'h00);
        check("reset.pending_a", {4'b0, pend_a}, 8'h00);
        check("reset.level_b",   lvl_b,          8'h00);

        // ch1 step, held: level after edge 6, single rise, sticky pending
        Reset_n   = 1'b1;
        din_a[1]  = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            cyc(1);
            if (e == 5) check("ch1.level_e5", {7'b0, lvl_a[1]}, 8'h00);
            if (e == 6) begin
                check("ch1.level_e6", {7'b0, lvl_a[1]},  8'h01);
                check("ch1.rise_e6",  {7'b0, rise_a[1]}, 8'h01);
                check("ch1.pend_e6",  {7'b0, pend_a[1]}, 8'h01);
            end
            if (e == 7) begin
                check("ch1.rise_e7", {7'b0, rise_a[1]}, 8'h00);
                check("ch1.pend_e7", {7'b0, pend_a[1]}, 8'h01);
            end
        end
        clr_a[1] = 1'b1; cyc(1); clr_a[1] = 1'b0;
        check("ch1.pend_clr",  {7'b0, pend_a[1]}, 8'h00);
        check("ch1.level_clr", {7'b0, lvl_a[1]},  8'h01);

        // ch2 glitch of 3 cycles is rejected
        din_a[2] = 1'b1; cyc(3); din_a[2] = 1'b0; cyc(10);
        check("ch2.glitch_level", {7'b0, lvl_a[2]},  8'h00);
        check("ch2.glitch_pend",  {7'b0, pend_a[2]}, 8'h00);

        // ch0: build pending, drop level, then clr on the same edge as a new rise
        din_a[0] = 1'b1; cyc(8); din_a[0] = 1'b0; cyc(8);
        check("ch0.pend_held", {7'b0, pend_a[0]}, 8'h01);
        check("ch0.level_low", {7'b0, lvl_a[0]},  8'h00);
        din_a[0] = 1'b1; cyc(5); clr_a[0] = 1'b1; cyc(1);
        check("ch0.rise_with_clr", {7'b0, rise_a[0]}, 8'h01);
        check("ch0.set_wins",      {7'b0, pend_a[0]}, 8'h01);
        cyc(1); clr_a[0] = 1'b0;
        check("ch0.clr_alone", {7'b0, pend_a[0]}, 8'h00);

        // ch3: rise, then fall pulse after edge 6, pending untouched
        din_a[3] = 1'b1; cyc(8);
        check("ch3.level_high", {7'b0, lvl_a[3]}, 8'h01);
        din_a[3] = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            cyc(1);
            if (e == 5) check("ch3.fall_e5", {7'b0, fall_a[3]}, 8'h00);
            if (e == 6) begin
                check("ch3.fall_e6",  {7'b0, fall_a[3]}, 8'h01);
                check("ch3.level_e6", {7'b0, lvl_a[3]},  8'h00);
                check("ch3.pend_e6",  {7'b0, pend_a[3]}, 8'h01);
            end
            if (e == 7) check("ch3.fall_e7", {7'b0, fall_a[3]}, 8'h00);
        end

        // ch0: reset mid-debounce (counter at 2), din held high through it
        din_a[0] = 1'b0; cyc(8);
        din_a[0] = 1'b1; cyc(4);
        Reset_n = 1'b0; cyc(1);
        check("rst.level_a", {4'b0, lvl_a},  8'h00);
        check("rst.pend_a",  {4'b0, pend_a}, 8'h00);
        check("rst.rf_a",    {4'b0, rise_a | fall_a}, 8'h00);
        Reset_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            cyc(1);
            if (e == 5) check("rst.ch0_level_e5", {7'b0, lvl_a[0]}, 8'h00);
            if (e == 6) begin
                check("rst.ch0_level_e6", {7'b0, lvl_a[0]},  8'h01);
                check("rst.ch0_rise_e6",  {7'b0, rise_a[0]}, 8'h01);
            end
            if (e == 7) check("rst.ch0_rise_e7", {7'b0, rise_a[0]}, 8'h00);
        end

        // mixed patterns on all channels, clr toggling
        for (int i = 0; i < 5; i++) begin
            din_a = pat[i];
            clr_a = {2'b0, i[0], ~i[0]};
            cyc(hold[i]);
        end
        clr_a = '0;
        cyc(10);

        // fast instance: single step on ch7
        din_b[7] = 1'b1;
        for (int e = 1; e <= 5; e++) begin
            cyc(1);
            if (e == 3) check("b.ch7_level_e3", lvl_b, 8'h00);
            if (e == 4) begin
                check("b.ch7_level_e4", lvl_b,  8'h80);
                check("b.ch7_rise_e4",  rise_b, 8'h80);
            end
            if (e == 5) check("b.ch7_rise_e5", rise_b, 8'h00);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
